boot_sequencer: RTL

- Drives the CPU boot-loader port (bl_programm_i, bl_data_i, bl_address_i, bl_write_en_mem_i) from a nibble stream received over a valid/ready handshake.
- Sits between the top-level pins and the cpu block. Holds the CPU in reset and owns program memory while loading.
- Sequence per load: clear all memory words to 0, write the incoming nibbles to consecutive addresses from 0, then release the CPU.

---
 rtl/boot_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the CPU in reset, clears program memory, streams nibbles
// into consecutive addresses over a valid/ready handshake, then releases the CPU.
module boot_sequencer #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16,
  parameter int RELEASE_CYCLES       = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            prog_req_i,
  input  logic                            load_valid_i,
  input  logic [REGISTER_WIDTH-1:0]       load_data_i,
  input  logic                            load_last_i,
  output logic                            load_ready_o,
  output logic                            bl_programm_o,
  output logic [REGISTER_WIDTH-1:0]       bl_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic                            bl_write_en_mem_o,
  output logic                            cpu_hold_o,
  output logic                            busy_o,
  output logic [MEMORY_ADDRESS_WIDTH:0]   words_loaded_o
);

  localparam int CW  = MEMORY_ADDRESS_WIDTH + 1;
  localparam int RCW = $clog2(RELEASE_CYCLES + 2);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  state_t                          state_r, state_s;
  logic                            prog_req_r;
  logic                            req_s;
  logic [CW-1:0]                   cnt_r, cnt_s;
  logic [RCW-1:0]                  rel_cnt_r, rel_cnt_s;
  logic [CW-1:0]                   words_r, words_s;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_r, addr_s;
  logic [REGISTER_WIDTH-1:0]       data_r, data_s;
  logic                            we_r, we_s;
  logic                            ready_r, ready_s;
  logic                            programm_r, programm_s;
  logic                            hold_r, hold_s;
  logic                            busy_r, busy_s;

  assign req_s = prog_req_i & ~prog_req_r;

  // Next state and next registered outputs; cnt_r holds the next address to write.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rel_cnt_s  = rel_cnt_r;
    words_s    = words_r;
    addr_s     = addr_r;
    data_s     = data_r;
    we_s       = 1'b0;
    ready_s    = 1'b0;
    programm_s = programm_r;
    hold_s     = hold_r;
    busy_s     = busy_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (req_s) begin
          state_s    = ST_CLEAR;
          cnt_s      = CW'(1);
          addr_s     = {MEMORY_ADDRESS_WIDTH{1'b0}};
          data_s     = {REGISTER_WIDTH{1'b0}};
          we_s       = 1'b1;
          programm_s = 1'b1;
          hold_s     = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CW'(MEMORY_REGISTERS)) begin
          state_s = ST_LOAD;
          cnt_s   = {CW{1'b0}};
          words_s = {CW{1'b0}};
          ready_s = 1'b1;
        end else begin
          addr_s = cnt_r[MEMORY_ADDRESS_WIDTH-1:0];
          data_s = {REGISTER_WIDTH{1'b0}};
          we_s   = 1'b1;
          cnt_s  = cnt_r + CW'(1);
        end
      end
      ST_LOAD: begin
        if (load_valid_i && ready_r) begin
          we_s    = 1'b1;
          data_s  = load_data_i;
          addr_s  = cnt_r[MEMORY_ADDRESS_WIDTH-1:0];
          cnt_s   = cnt_r + CW'(1);
          words_s = words_r + CW'(1);
          // The last address ends the load even without load_last_i: no wrap.
          if (load_last_i || (cnt_r == CW'(MEMORY_REGISTERS - 1))) begin
            state_s   = ST_RELEASE;
            rel_cnt_s = {RCW{1'b0}};
            ready_s   = 1'b0;
          end else begin
            ready_s = 1'b1;
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_r == RCW'(RELEASE_CYCLES)) begin
          state_s    = ST_RUN;
          programm_s = 1'b0;
          hold_s     = 1'b0;
          busy_s     = 1'b0;
        end else begin
          rel_cnt_s = rel_cnt_r + RCW'(1);
        end
      end
      default: begin
        state_s    = ST_IDLE;
        programm_s = 1'b0;
        hold_s     = 1'b1;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State, request-edge history and registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= ST_IDLE;
      prog_req_r <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      rel_cnt_r  <= {RCW{1'b0}};
      words_r    <= {CW{1'b0}};
      addr_r     <= {MEMORY_ADDRESS_WIDTH{1'b0}};
      data_r     <= {REGISTER_WIDTH{1'b0}};
      we_r       <= 1'b0;
      ready_r    <= 1'b0;
      programm_r <= 1'b0;
      hold_r     <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      prog_req_r <= prog_req_i;
      cnt_r      <= cnt_s;
      rel_cnt_r  <= rel_cnt_s;
      words_r    <= words_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      we_r       <= we_s;
      ready_r    <= ready_s;
      programm_r <= programm_s;
      hold_r     <= hold_s;
      busy_r     <= busy_s;
    end
  end

  assign load_ready_o      = ready_r;
  assign bl_programm_o     = programm_r;
  assign bl_data_o         = data_r;
  assign bl_address_o      = addr_r;
  assign bl_write_en_mem_o = we_r;
  assign cpu_hold_o        = hold_r;
  assign busy_o            = busy_r;
  assign words_loaded_o    = words_r;

endmodule
